// File: rtl/piso_shift_tx_pkg.sv
// Shared types and helpers for the parallel-in/serial-out transmit shifter.
package piso_shift_tx_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/piso_shift_tx_if.sv
// Word handshake and serial output bundle of piso_shift_tx.
interface piso_shift_tx_if #(
  parameter int WIDTH = piso_shift_tx_pkg::DEFAULT_WIDTH
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             sout_last;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, sout, sout_valid, sout_last, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, sout, sout_valid, sout_last, busy
  );
endinterface

// File: rtl/piso_shift_tx_shifter.sv
// Shift register and bit counter: loads a word, then moves it out MSB first.
module piso_shifter
  import piso_shift_tx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb,
  output logic             last
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;

  // A load takes priority so a new word can follow the last bit with no gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (load) begin
      sreg <= din;
      cnt  <= '0;
    end else if (shift) begin
      sreg <= {sreg[WIDTH-2:0], 1'b0};
      cnt  <= cnt + CW'(1);
    end
  end

  assign msb  = sreg[WIDTH-1];
  assign last = (cnt == LAST_CNT);

endmodule

// File: rtl/piso_shift_tx.sv
// Transmit shifter top: one-word hold buffer, valid/ready intake and IDLE/SHIFT FSM.
module piso_shift_tx
  import piso_shift_tx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  piso_shift_tx_if.slave bus
);

  state_t           state;
  logic [WIDTH-1:0] hold;
  logic             hold_valid;
  logic             in_shift;
  logic             shift_msb;
  logic             shift_last;
  logic             load_now;
  logic             accept;

  assign in_shift = (state == SHIFT);
  assign load_now = hold_valid && (!in_shift || shift_last);
  // The hold slot frees in the same cycle its word moves into the shifter.
  assign bus.din_ready = !hold_valid || load_now;
  assign accept        = bus.din_valid && bus.din_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hold       <= '0;
      hold_valid <= 1'b0;
    end else begin
      if (accept) begin
        hold <= bus.din;
      end

      if (accept) begin
        hold_valid <= 1'b1;
      end else if (load_now) begin
        hold_valid <= 1'b0;
      end

      if (load_now) begin
        state <= SHIFT;
      end else if (in_shift && shift_last) begin
        state <= IDLE;
      end
    end
  end

  piso_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk   (clk),
    .rst   (rst),
    .load  (load_now),
    .shift (in_shift),
    .din   (hold),
    .msb   (shift_msb),
    .last  (shift_last)
  );

  assign bus.sout       = in_shift && shift_msb;
  assign bus.sout_valid = in_shift;
  assign bus.sout_last  = in_shift && shift_last;
  assign bus.busy       = in_shift || hold_valid;

endmodule
